// File: rtl/fetch_sequencer.sv
// Instruction-fetch initiator: one-cycle program-memory read, decode, valid/done issue, ARC-style branches, halt on all-zero word.
// Optional retired-instruction counter behind FETCH_RETIRE_CNT_EN. Latency: 3+ cycles per instruction, 3 per branch; stalls in S_ISSUE until Exec_Done.
module fetch_sequencer #(
  parameter int                     DATAWIDTH_BUS = 32,
  parameter logic [DATAWIDTH_BUS-1:0] RESET_PC    = 'h0000_0800
) (
  input  logic                     CLOCK_50,
  input  logic                     RESET_InLow,
  output logic                     RD,
  output logic                     WR,
  output logic [DATAWIDTH_BUS-1:0] BusDirecciones,
  input  logic [DATAWIDTH_BUS-1:0] BusDatos,
  output logic [DATAWIDTH_BUS-1:0] IR,
  output logic                     IR_Valid,
  input  logic                     Exec_Done,
  input  logic                     CC_N,
  input  logic                     CC_Z,
  input  logic                     CC_V,
  input  logic                     CC_C,
`ifdef FETCH_RETIRE_CNT_EN
  output logic [31:0]              Retired_Count,
`endif
  output logic [DATAWIDTH_BUS-1:0] PC,
  output logic                     Halted
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_ISSUE  = 3'd2,
    S_BRANCH = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  state_t                   state, stateNext;
  logic [DATAWIDTH_BUS-1:0] pcNext, irNext, pcPlus4, branchTarget;
  logic                     isBranch, takeBranch, retireNow;

  assign pcPlus4      = PC + DATAWIDTH_BUS'(4);
  assign branchTarget = PC + {{(DATAWIDTH_BUS-22){IR[21]}}, IR[21:0]};
  assign isBranch     = (IR[31:30] == 2'b00) && (IR[24:22] == 3'b010);

  always_comb begin
    takeBranch = 1'b0;
    unique case (IR[28:25])
      4'b1000: takeBranch = 1'b1;
      4'b0001: takeBranch = CC_Z;
      4'b0101: takeBranch = CC_C;
      4'b0110: takeBranch = CC_N;
      4'b0111: takeBranch = CC_V;
      default: takeBranch = 1'b0;
    endcase
  end

  always_comb begin
    stateNext = state;
    pcNext    = PC;
    irNext    = IR;
    retireNow = 1'b0;
    RD        = 1'b0;
    IR_Valid  = 1'b0;
    Halted    = 1'b0;
    unique case (state)
      S_FETCH: begin
        RD        = 1'b1;
        irNext    = BusDatos;
        stateNext = S_DECODE;
      end
      S_DECODE: begin
        if (IR == '0)
          stateNext = S_HALT;
        else if (isBranch)
          stateNext = S_BRANCH;
        else
          stateNext = S_ISSUE;
      end
      S_ISSUE: begin
        IR_Valid = 1'b1;
        if (Exec_Done) begin
          pcNext    = pcPlus4;
          retireNow = 1'b1;
          stateNext = S_FETCH;
        end
      end
      S_BRANCH: begin
        pcNext    = takeBranch ? branchTarget : pcPlus4;
        retireNow = 1'b1;
        stateNext = S_FETCH;
      end
      S_HALT: begin
        Halted = 1'b1;
      end
      default: stateNext = S_FETCH;
    endcase
  end

  assign WR             = 1'b0;
  assign BusDirecciones = RD ? PC : '0;

  always_ff @(posedge CLOCK_50) begin
    if (!RESET_InLow) begin
      state <= S_FETCH;
      PC    <= RESET_PC;
      IR    <= '0;
    end else begin
      state <= stateNext;
      PC    <= pcNext;
      IR    <= irNext;
    end
  end

`ifdef FETCH_RETIRE_CNT_EN
  // Saturating count of instructions leaving S_ISSUE or S_BRANCH.
  always_ff @(posedge CLOCK_50) begin
    if (!RESET_InLow)
      Retired_Count <= '0;
    else if (retireNow && (Retired_Count != 32'hFFFF_FFFF))
      Retired_Count <= Retired_Count + 32'd1;
  end
`else
  logic unusedRetire;
  assign unusedRetire = retireNow;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: combinational program memory model, per-feature tasks with inline checks.
module tb_fetch_sequencer;

  localparam logic [31:0] NOP  = 32'h8280_2001;
  localparam logic [31:0] BNEG = 32'h0CBF_FFF0;
  localparam logic [31:0] BA24 = 32'h10BF_FFE8;
  localparam logic [31:0] BE12 = 32'h0280_000C;

  logic        CLOCK_50 = 1'b0;
  logic        RESET_InLow = 1'b0;
  logic        RD, WR, IR_Valid, Halted;
  logic [31:0] BusDirecciones, BusDatos, IR, PC;
  logic        Exec_Done = 1'b0;
  logic        CC_N = 1'b0, CC_Z = 1'b0, CC_V = 1'b0, CC_C = 1'b0;
`ifdef FETCH_RETIRE_CNT_EN
  logic [31:0] Retired_Count;
`endif

  logic [31:0] mem [64];
  int checks = 0;
  int errors = 0;

  assign BusDatos = mem[BusDirecciones[7:2]];

  always #5 CLOCK_50 = ~CLOCK_50;

  fetch_sequencer dut (
    .CLOCK_50       (CLOCK_50),
    .RESET_InLow    (RESET_InLow),
    .RD             (RD),
    .WR             (WR),
    .BusDirecciones (BusDirecciones),
    .BusDatos       (BusDatos),
    .IR             (IR),
    .IR_Valid       (IR_Valid),
    .Exec_Done      (Exec_Done),
    .CC_N           (CC_N),
    .CC_Z           (CC_Z),
    .CC_V           (CC_V),
    .CC_C           (CC_C),
`ifdef FETCH_RETIRE_CNT_EN
    .Retired_Count  (Retired_Count),
`endif
    .PC             (PC),
    .Halted         (Halted)
  );

  task automatic load_main();
    for (int i = 0; i < 64; i++) mem[i] = NOP;
    mem[8]  = BNEG;   // 0x820
    mem[13] = BE12;   // 0x834
    mem[15] = BA24;   // 0x83C
    mem[16] = 32'h0;  // 0x840 fin
  endtask

  // One reset cycle; returns at the negedge of the first fetch cycle.
  task automatic do_reset();
    @(negedge CLOCK_50);
    RESET_InLow = 1'b0;
    @(negedge CLOCK_50);
    RESET_InLow = 1'b1;
  endtask

  // Advances to the next fetch cycle (sampled at negedge), bounded.
  task automatic next_fetch(output logic [31:0] addr, output bit ok);
    ok   = 1'b0;
    addr = 32'hDEAD_BEEF;
    for (int c = 0; c < 40; c++) begin
      @(negedge CLOCK_50);
      if (RD) begin
        addr = BusDirecciones;
        ok   = 1'b1;
        return;
      end
    end
  endtask

  task automatic seek(input logic [31:0] target);
    logic [31:0] a;
    bit ok;
    for (int n = 0; n < 30; n++) begin
      next_fetch(a, ok);
      if (!ok || a == target) break;
    end
    checks++;
    if (a !== target) begin
      errors++;
      $display("FAIL seek_%h: reached %h, required %h", target, a, target);
    end
  endtask

  task automatic test_reset();
    load_main();
    Exec_Done = 1'b0;
    do_reset();
    checks++;
    if (PC !== 32'h800 || IR !== 32'h0 || IR_Valid !== 1'b0 || Halted !== 1'b0 || WR !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: PC=%h IR=%h vld=%b halt=%b wr=%b, required 800/0/0/0/0",
               PC, IR, IR_Valid, Halted, WR);
    end
`ifdef FETCH_RETIRE_CNT_EN
    checks++;
    if (Retired_Count !== 32'd0) begin
      errors++;
      $display("FAIL reset_count: got %0d, required 0", Retired_Count);
    end
`endif
  endtask

  task automatic test_first_fetch();
    checks++;
    if (RD !== 1'b1 || BusDirecciones !== 32'h800) begin
      errors++;
      $display("FAIL first_fetch: RD=%b addr=%h, required 1/00000800", RD, BusDirecciones);
    end
    @(negedge CLOCK_50);
    checks++;
    if (RD !== 1'b0 || BusDirecciones !== 32'h0 || IR !== NOP || IR_Valid !== 1'b0) begin
      errors++;
      $display("FAIL decode_cycle: RD=%b addr=%h IR=%h vld=%b, required 0/0/%h/0",
               RD, BusDirecciones, IR, IR_Valid, NOP);
    end
    @(negedge CLOCK_50);
    checks++;
    if (IR_Valid !== 1'b1 || IR !== NOP) begin
      errors++;
      $display("FAIL issue_valid: vld=%b IR=%h, required 1/%h", IR_Valid, IR, NOP);
    end
  endtask

  // Entered at the negedge of the first S_ISSUE cycle.
  task automatic test_issue_hold();
    int vldCnt = 0;
    int rdCnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (IR_Valid) vldCnt++;
      if (RD) rdCnt++;
      Exec_Done = (i == 5);
      @(negedge CLOCK_50);
    end
    Exec_Done = 1'b0;
    checks++;
    if (vldCnt != 6 || rdCnt != 0) begin
      errors++;
      $display("FAIL issue_hold: valid cycles %0d rd pulses %0d, required 6/0", vldCnt, rdCnt);
    end
    checks++;
    if (RD !== 1'b1 || BusDirecciones !== 32'h804 || IR_Valid !== 1'b0) begin
      errors++;
      $display("FAIL next_fetch_804: RD=%b addr=%h vld=%b, required 1/00000804/0",
               RD, BusDirecciones, IR_Valid);
    end
  endtask

  // Entered at the fetch of 0x804; stalls it in S_ISSUE then resets.
  task automatic test_reset_in_issue();
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    checks++;
    if (IR_Valid !== 1'b1 || PC !== 32'h804) begin
      errors++;
      $display("FAIL issue_804: vld=%b PC=%h, required 1/00000804", IR_Valid, PC);
    end
    RESET_InLow = 1'b0;
    Exec_Done   = 1'b1;
    @(negedge CLOCK_50);
    RESET_InLow = 1'b1;
    Exec_Done   = 1'b0;
    checks++;
    if (IR_Valid !== 1'b0 || PC !== 32'h800 || IR !== 32'h0 || RD !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_issue: vld=%b PC=%h IR=%h RD=%b, required 0/00000800/0/1",
               IR_Valid, PC, IR, RD);
    end
  endtask

  task automatic test_branches();
    logic [31:0] a;
    bit ok;
    Exec_Done = 1'b1;
    seek(32'h820);
    CC_N = 1'b1;
    next_fetch(a, ok);
    CC_N = 1'b0;
    checks++;
    if (a !== 32'h810) begin
      errors++;
      $display("FAIL bneg_taken: fetch %h, required 00000810", a);
    end
    seek(32'h820);
    next_fetch(a, ok);
    checks++;
    if (a !== 32'h824) begin
      errors++;
      $display("FAIL bneg_not_taken: fetch %h, required 00000824", a);
    end
    seek(32'h834);
    next_fetch(a, ok);
    checks++;
    if (a !== 32'h838) begin
      errors++;
      $display("FAIL be_not_taken: fetch %h, required 00000838", a);
    end
    next_fetch(a, ok);
    next_fetch(a, ok);
    checks++;
    if (a !== 32'h824) begin
      errors++;
      $display("FAIL ba_back: fetch %h, required 00000824", a);
    end
    seek(32'h834);
    CC_Z = 1'b1;
    next_fetch(a, ok);
    CC_Z = 1'b0;
    checks++;
    if (a !== 32'h840) begin
      errors++;
      $display("FAIL be_taken: fetch %h, required 00000840", a);
    end
  endtask

  // Entered at the fetch of the fin word at 0x840.
  task automatic test_halt();
    int rdCnt = 0;
    int badCnt = 0;
    @(negedge CLOCK_50);
    for (int i = 0; i < 22; i++) begin
      @(negedge CLOCK_50);
      if (RD !== 1'b0) rdCnt++;
      if (Halted !== 1'b1 || PC !== 32'h840 || IR_Valid !== 1'b0) badCnt++;
    end
    checks++;
    if (rdCnt != 0 || badCnt != 0) begin
      errors++;
      $display("FAIL halt_hold: rd pulses %0d bad cycles %0d (PC=%h halt=%b), required 0/0",
               rdCnt, badCnt, PC, Halted);
    end
    Exec_Done = 1'b0;
    do_reset();
    checks++;
    if (Halted !== 1'b0 || RD !== 1'b1 || BusDirecciones !== 32'h800) begin
      errors++;
      $display("FAIL halt_reset: halt=%b RD=%b addr=%h, required 0/1/00000800",
               Halted, RD, BusDirecciones);
    end
  endtask

`ifdef FETCH_RETIRE_CNT_EN
  // nop, bn (never), ba +8, nop, fin: four retirements.
  task automatic test_retire_count();
    for (int i = 0; i < 64; i++) mem[i] = NOP;
    mem[1] = 32'h0080_0008;
    mem[2] = 32'h1080_0008;
    mem[5] = 32'h0;
    Exec_Done = 1'b1;
    do_reset();
    seek(32'h814);
    for (int i = 0; i < 5; i++) @(negedge CLOCK_50);
    checks++;
    if (Retired_Count !== 32'd4 || Halted !== 1'b1) begin
      errors++;
      $display("FAIL retire_count: got %0d halt=%b, required 4/1", Retired_Count, Halted);
    end
    for (int i = 0; i < 10; i++) @(negedge CLOCK_50);
    checks++;
    if (Retired_Count !== 32'd4) begin
      errors++;
      $display("FAIL retire_frozen: got %0d, required 4", Retired_Count);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_first_fetch();
    test_issue_hold();
    test_reset_in_issue();
    test_branches();
    test_halt();
`ifdef FETCH_RETIRE_CNT_EN
    test_retire_count();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
